// File: rtl/nbit_pipe_addsub.sv
// Pipelined N-bit add/subtract: SEG segments, ripple carry/borrow registered between stages.
// Latency: SEG cycles from input handshake to out_valid; one beat per cycle when unstalled.
// Backpressure: per-stage elastic, bubbles collapse; in_ready drops only when every stage is full and the output is stalled.
module nbit_pipe_addsub #(
    parameter int N   = 8,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         BI,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] D,
    output logic         BO,
    output logic         OVF,
    output logic         Z
);
    localparam int W = N / SEG;

    // One beat as it moves down the pipe. Full operands travel along because the
    // final stage needs their sign bits for overflow; d accumulates finished segments
    // and c is the carry/borrow out of the most recently resolved segment.
    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] d;
        logic         mode;
        logic         c;
        logic         ovf;
        logic         z;
    } beat_t;

    beat_t            st_q [SEG];
    logic [SEG-1:0]   vld_q;
    beat_t            src  [SEG];
    beat_t            nxt  [SEG];
    logic [SEG-1:0]   adv;
    logic [SEG-1:0]   load;

    // Flow control: walk back from the output; a stage is blocked only if its
    // successor is occupied and blocked, so empty stages always absorb upstream beats.
    always_comb begin
        logic blk;
        adv      = '0;
        load     = '0;
        in_ready = 1'b0;
        blk      = vld_q[SEG-1] && !out_ready;
        for (int k = SEG-1; k >= 0; k--) begin
            adv[k] = vld_q[k] && !blk;
            blk    = vld_q[k] && blk;
        end
        in_ready = !blk;
        load[0]  = in_valid && in_ready;
        for (int k = 1; k < SEG; k++) begin
            load[k] = adv[k-1];
        end
    end

    // Segment datapath: stage k resolves bits [k*W +: W] using the carry/borrow
    // handed over by its predecessor (stage 0 takes BI directly).
    always_comb begin
        logic [W:0] sum;
        sum         = '0;
        src[0]      = '0;
        src[0].a    = A;
        src[0].b    = B;
        src[0].mode = mode;
        src[0].c    = BI;
        for (int k = 1; k < SEG; k++) begin
            src[k] = st_q[k-1];
        end
        for (int k = 0; k < SEG; k++) begin
            if (src[k].mode) begin
                sum = {1'b0, src[k].a[k*W +: W]} + {1'b0, src[k].b[k*W +: W]}
                    + {{W{1'b0}}, src[k].c};
            end else begin
                // Negative segment result wraps, leaving bit W set as the borrow.
                sum = {1'b0, src[k].a[k*W +: W]} - {1'b0, src[k].b[k*W +: W]}
                    - {{W{1'b0}}, src[k].c};
            end
            nxt[k]              = src[k];
            nxt[k].d[k*W +: W]  = sum[W-1:0];
            nxt[k].c            = sum[W];
            // Only meaningful once the top segment is resolved (last stage).
            if (src[k].mode) begin
                nxt[k].ovf = (src[k].a[N-1] == src[k].b[N-1]) && (nxt[k].d[N-1] != src[k].a[N-1]);
            end else begin
                nxt[k].ovf = (src[k].a[N-1] != src[k].b[N-1]) && (nxt[k].d[N-1] != src[k].a[N-1]);
            end
            nxt[k].z = (nxt[k].d == '0);
        end
    end

    // Stage registers: a stage loads when its predecessor advances and empties when it
    // advances without being refilled; a reset drops every beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < SEG; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SEG; k++) begin
                vld_q[k] <= load[k] || (vld_q[k] && !adv[k]);
                if (load[k]) begin
                    st_q[k] <= nxt[k];
                end
            end
        end
    end

    assign out_valid = vld_q[SEG-1];
    assign D         = st_q[SEG-1].d;
    assign BO        = st_q[SEG-1].c;
    assign OVF       = st_q[SEG-1].ovf;
    assign Z         = st_q[SEG-1].z;

endmodule

// File: tb/tb_nbit_pipe_addsub.sv
`timescale 1ns/1ps
module tb_nbit_pipe_addsub;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ovf;
        logic        z;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic       md;
        logic [7:0] d;
        logic       bo;
        logic       ovf;
        logic       z;
    } vec_t;

    typedef struct {
        res_t r;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- main instance: N=8, SEG=4 ----------------
    logic       m_iv, m_ir, m_bi, m_md, m_ov, m_or, m_bo, m_ovf, m_z;
    logic [7:0] m_a, m_b, m_d;

    nbit_pipe_addsub #(.N(8), .SEG(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir),
        .A(m_a), .B(m_b), .BI(m_bi), .mode(m_md),
        .out_valid(m_ov), .out_ready(m_or), .D(m_d), .BO(m_bo), .OVF(m_ovf), .Z(m_z));

    // ---------------- sweep instances ----------------
    logic [31:0] a0, b0, d0, a1, b1, d1;
    logic [15:0] a2, b2, d2;
    logic        s_iv [3], s_ir [3], s_bi [3], s_md [3], s_ov [3], s_or [3];
    logic        s_bo [3], s_ovf [3], s_z [3];

    nbit_pipe_addsub #(.N(32), .SEG(1)) dut_32_1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_iv[0]), .in_ready(s_ir[0]),
        .A(a0), .B(b0), .BI(s_bi[0]), .mode(s_md[0]),
        .out_valid(s_ov[0]), .out_ready(s_or[0]), .D(d0), .BO(s_bo[0]), .OVF(s_ovf[0]), .Z(s_z[0]));

    nbit_pipe_addsub #(.N(32), .SEG(8)) dut_32_8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_iv[1]), .in_ready(s_ir[1]),
        .A(a1), .B(b1), .BI(s_bi[1]), .mode(s_md[1]),
        .out_valid(s_ov[1]), .out_ready(s_or[1]), .D(d1), .BO(s_bo[1]), .OVF(s_ovf[1]), .Z(s_z[1]));

    nbit_pipe_addsub #(.N(16), .SEG(16)) dut_16_16 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_iv[2]), .in_ready(s_ir[2]),
        .A(a2), .B(b2), .BI(s_bi[2]), .mode(s_md[2]),
        .out_valid(s_ov[2]), .out_ready(s_or[2]), .D(d2), .BO(s_bo[2]), .OVF(s_ovf[2]), .Z(s_z[2]));

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Whole-word reference: plain modular arithmetic on n-bit unsigned values.
    function automatic res_t ref_model(input int n, input logic [31:0] a, input logic [31:0] b,
                                       input logic bi, input logic md);
        res_t r;
        logic [63:0] mask, aa, bb, s;
        logic sa, sb, sd;
        mask = (64'd1 << n) - 64'd1;
        aa   = {32'b0, a} & mask;
        bb   = {32'b0, b} & mask;
        if (md) begin
            s    = aa + bb + 64'(bi);
            r.bo = s[n];
        end else begin
            s    = aa - bb - 64'(bi);
            r.bo = aa < (bb + 64'(bi));
        end
        r.d   = 32'(s & mask);
        sa    = aa[n-1];
        sb    = bb[n-1];
        sd    = r.d[n-1];
        r.ovf = md ? (sa == sb && sd != sa) : (sa != sb && sd != sa);
        r.z   = (r.d == 32'd0);
        return r;
    endfunction

    // ---------------- main-instance driver / scoreboard ----------------
    exp_t       mq[$];
    int         t = 0;
    int         occ = 0;
    logic       cur_vld = 1'b0, cur_bi = 1'b0, cur_md = 1'b0, cur_lat = 1'b0;
    logic [7:0] cur_a = '0, cur_b = '0;
    res_t       cur_exp = '0;
    logic       prev_stall = 1'b0;
    res_t       prev_out = '0;

    task automatic main_cycle(input logic ordy);
        res_t got;
        exp_t e;
        logic fin, fout;
        @(negedge clk);
        m_iv = cur_vld; m_a = cur_a; m_b = cur_b; m_bi = cur_bi; m_md = cur_md; m_or = ordy;
        #1;
        check("in_ready", m_ir, !(occ == 4 && !ordy));
        got = '{d: {24'b0, m_d}, bo: m_bo, ovf: m_ovf, z: m_z};
        if (prev_stall) begin
            check("hold_valid", m_ov, 1'b1);
            check("hold_data", got, prev_out);
        end
        fin  = m_iv && m_ir;
        fout = m_ov && m_or;
        if (m_ov && mq.size() == 0) begin
            check("spurious_out", m_ov, 1'b0);
        end else if (fout) begin
            e = mq.pop_front();
            check("result", got, e.r);
            if (e.due >= 0) check("latency", t, e.due);
        end
        if (fin) begin
            mq.push_back('{r: cur_exp, due: cur_lat ? t + 4 : -1});
            cur_vld = 1'b0;
        end
        occ = occ + int'(fin) - int'(fout && mq.size() >= 0);
        prev_stall = m_ov && !ordy;
        prev_out   = got;
        t++;
    endtask

    task automatic set_vec(input vec_t v);
        cur_a = v.a; cur_b = v.b; cur_bi = v.bi; cur_md = v.md;
        cur_exp = '{d: {24'b0, v.d}, bo: v.bo, ovf: v.ovf, z: v.z};
        cur_lat = 1'b1;
        cur_vld = 1'b1;
    endtask

    // ---------------- sweep driver / scoreboard ----------------
    function automatic int nw(input int i);
        return (i == 2) ? 16 : 32;
    endfunction
    function automatic int sg(input int i);
        case (i)
            0:       return 1;
            1:       return 8;
            default: return 16;
        endcase
    endfunction

    task automatic run_sweep();
        logic        w_vld [3];
        logic [31:0] w_a [3], w_b [3];
        logic        w_bi [3], w_md [3], ordy [3];
        res_t        rb [3][32];
        int          hd [3], tl [3], socc [3];
        res_t        got;
        logic        fin, fout;
        for (int i = 0; i < 3; i++) begin
            w_vld[i] = 1'b0; w_a[i] = '0; w_b[i] = '0; w_bi[i] = 1'b0; w_md[i] = 1'b0;
            hd[i] = 0; tl[i] = 0; socc[i] = 0; ordy[i] = 1'b0;
        end
        for (int c = 0; c < 700; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!w_vld[i] && c < 600 && $urandom_range(0, 9) < 8) begin
                    w_a[i] = $urandom;
                    w_b[i] = $urandom;
                    case ($urandom_range(0, 7))
                        0: w_a[i] = '0;
                        1: w_a[i] = '1;
                        2: w_b[i] = w_a[i];
                        default: ;
                    endcase
                    w_bi[i]  = ($urandom_range(0, 1) == 1);
                    w_md[i]  = ($urandom_range(0, 1) == 1);
                    w_vld[i] = 1'b1;
                end
                ordy[i] = (c >= 600) || ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            a0 = w_a[0]; b0 = w_b[0]; a1 = w_a[1]; b1 = w_b[1];
            a2 = w_a[2][15:0]; b2 = w_b[2][15:0];
            for (int i = 0; i < 3; i++) begin
                s_iv[i] = w_vld[i]; s_bi[i] = w_bi[i]; s_md[i] = w_md[i]; s_or[i] = ordy[i];
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                case (i)
                    0:       got.d = d0;
                    1:       got.d = d1;
                    default: got.d = {16'b0, d2};
                endcase
                got.bo = s_bo[i]; got.ovf = s_ovf[i]; got.z = s_z[i];
                check("sw_in_ready", s_ir[i], !(socc[i] == sg(i) && !ordy[i]));
                fin  = s_iv[i] && s_ir[i];
                fout = s_ov[i] && s_or[i];
                if (s_ov[i] && hd[i] == tl[i]) begin
                    check("sw_spurious", s_ov[i], 1'b0);
                end else if (fout) begin
                    check("sw_result", got, rb[i][hd[i] % 32]);
                    hd[i]++;
                end
                if (fin) begin
                    rb[i][tl[i] % 32] = ref_model(nw(i), w_a[i], w_b[i], w_bi[i], w_md[i]);
                    tl[i]++;
                    w_vld[i] = 1'b0;
                end
                socc[i] = tl[i] - hd[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            check("sw_drain", tl[i] - hd[i], 0);
        end
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl [12];

    initial begin
        tbl[0]  = '{8'd10,  8'd15,  1'b0, 1'b0, 8'd251, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{8'd50,  8'd17,  1'b1, 1'b0, 8'd32,  1'b0, 1'b0, 1'b0};
        tbl[2]  = '{8'd189, 8'd20,  1'b0, 1'b1, 8'd209, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{8'd1,   8'd1,   1'b1, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{8'd255, 8'd1,   1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 1'b1};
        tbl[5]  = '{8'd127, 8'd1,   1'b0, 1'b1, 8'd128, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{8'd128, 8'd1,   1'b0, 1'b0, 8'd127, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{8'd0,   8'd1,   1'b0, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{8'd77,  8'd77,  1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1};
        tbl[9]  = '{8'd200, 8'd100, 1'b1, 1'b1, 8'd45,  1'b1, 1'b0, 1'b0};
        tbl[10] = '{8'd128, 8'd128, 1'b0, 1'b1, 8'd0,   1'b1, 1'b1, 1'b1};
        tbl[11] = '{8'd100, 8'd200, 1'b0, 1'b0, 8'd156, 1'b1, 1'b1, 1'b0};

        m_iv = 1'b0; m_a = '0; m_b = '0; m_bi = 1'b0; m_md = 1'b0; m_or = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        for (int i = 0; i < 3; i++) begin
            s_iv[i] = 1'b0; s_bi[i] = 1'b0; s_md[i] = 1'b0; s_or[i] = 1'b0;
        end

        // Reset state
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", m_ov, 1'b0);
        check("rst_D", m_d, 8'd0);
        check("rst_BO", m_bo, 1'b0);
        check("rst_OVF", m_ovf, 1'b0);
        check("rst_Z", m_z, 1'b0);
        check("rst_in_ready", m_ir, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, back-to-back, out_ready=1: each result exactly 4 cycles after its handshake
        for (int j = 0; j < 12; j++) begin
            set_vec(tbl[j]);
            main_cycle(1'b1);
        end
        cur_vld = 1'b0;
        for (int k = 0; k < 20 && mq.size() > 0; k++) main_cycle(1'b1);
        check("drain_table", mq.size(), 0);

        // Backpressure: 8 random beats, out_ready toggles every 3 cycles
        begin
            int n_in;
            n_in = 0;
            for (int c = 0; c < 200 && (n_in < 8 || mq.size() > 0 || cur_vld); c++) begin
                if (!cur_vld && n_in < 8) begin
                    cur_a = 8'($urandom); cur_b = 8'($urandom);
                    cur_bi = ($urandom_range(0, 1) == 1); cur_md = ($urandom_range(0, 1) == 1);
                    cur_exp = ref_model(8, {24'b0, cur_a}, {24'b0, cur_b}, cur_bi, cur_md);
                    cur_lat = 1'b0;
                    cur_vld = 1'b1;
                    n_in++;
                end
                main_cycle(((c / 3) % 2) == 0);
            end
            check("drain_bp", mq.size(), 0);
        end

        // Reset mid-operation with 3 beats in flight and the output stalled
        for (int j = 0; j < 3; j++) begin
            set_vec(tbl[j]);
            main_cycle(1'b0);
        end
        main_cycle(1'b0);
        main_cycle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", m_ov, 1'b0);
        check("midrst_D", m_d, 8'd0);
        check("midrst_BO", m_bo, 1'b0);
        check("midrst_Z", m_z, 1'b0);
        check("midrst_in_ready", m_ir, 1'b1);
        mq.delete();
        occ = 0;
        prev_stall = 1'b0;
        cur_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) main_cycle(1'b1);
        set_vec('{8'd10, 8'd4, 1'b0, 1'b0, 8'd6, 1'b0, 1'b0, 1'b0});
        main_cycle(1'b1);
        for (int k = 0; k < 10 && mq.size() > 0; k++) main_cycle(1'b1);
        check("drain_after_rst", mq.size(), 0);

        // Parameter sweep with random operands against the reference model
        run_sweep();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1);
    end

endmodule
